instr_fetch: RTL and testbench
==============================

// Module: instr_fetch
// PURPOSE
//  Instruction fetch/IR unit: the consumer of the program counter address.
//  On a fetch request it reads two bytes from the byte-wide program ROM at the
//  current pc_addr (high byte first) and emits one pc_inc pulse per byte consumed.
//  It assembles {opcode, ir_addr}, which feeds the controller and the PC's
//  jump-load path.
// PARAMETERS
//  ADDR_W       13  instruction/ROM address width; ir_addr width
//  OPC_W         3  opcode width; OPC_W+ADDR_W must equal 2*BYTE_W
//  BYTE_W        8  ROM data width
//  TIMEOUT_CYC  15  max wait cycles per ROM byte (FETCH_TIMEOUT_EN only), >=2
// PORTS
//  clk          in   1       system clock, rising edge
//  rst_n        in   1       synchronous active-low reset
//  fetch_start  in   1       request one instruction fetch; sampled in IDLE only
//  pc_addr      in   ADDR_W  current program counter address
//  pc_inc       out  1       1-cycle pulse: advance PC by one byte
//  rom_rd       out  1       ROM read request; held until rom_ack
//  rom_addr     out  ADDR_W  ROM byte address, stable while rom_rd=1
//  rom_ack      in   1       ROM data valid this cycle; ignored unless rom_rd=1
//  rom_data     in   BYTE_W  ROM read data, valid with rom_ack
//  opcode       out  OPC_W   instruction opcode, updated in DONE
//  ir_addr      out  ADDR_W  instruction address field, updated in DONE
//  ir_valid     out  1       1-cycle pulse: opcode/ir_addr newly valid
//  busy         out  1       1 in every state except IDLE
//  fetch_err    out  1       1-cycle pulse: ROM timeout (0 without the macro)
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): state=IDLE. All outputs are 0: rom_rd, rom_addr,
//   pc_inc, opcode, ir_addr, ir_valid, busy and fetch_err. The hi-byte holding
//   register is also cleared.
//  FSM: IDLE -> REQ_HI -> INC_HI -> REQ_LO -> DONE -> IDLE. All outputs registered.
//   IDLE:   fetch_start=1 -> REQ_HI; rom_addr<=pc_addr at this edge.
//   REQ_HI: rom_rd=1. On rom_ack: hi<=rom_data, rom_rd drops next cycle -> INC_HI.
//           Without rom_ack: stay.
//   INC_HI: pc_inc=1 for exactly this cycle -> REQ_LO; rom_addr<=pc_addr at exit edge.
//   REQ_LO: rom_rd=1. On rom_ack: {opcode,ir_addr}<={hi,rom_data} -> DONE.
//   DONE:   pc_inc=1 and ir_valid=1 for this cycle -> IDLE.
//  Latency: zero-wait ROM (ack in first rom_rd cycle), fetch_start seen at edge n:
//   rom_rd in n+1 and n+3; pc_inc in n+2 and n+4; ir_valid in n+4; idle in n+5.
//   Each ROM wait cycle adds one cycle.
//  Exactly 2 pc_inc pulses per completed fetch; pc_inc is never high 2 cycles in a row.
//  fetch_start outside IDLE (including DONE) is ignored, not queued.
//  rom_ack while rom_rd=0 is ignored.
//  opcode/ir_addr hold their value between fetches. They change only at the
//   REQ_LO->DONE edge.
//  rom_addr wraps naturally with the PC. No arithmetic is done on it here.
//  Reset mid-fetch: abort immediately. No further pc_inc. opcode/ir_addr are cleared.
//  rom_ack in the same cycle as rst_n=0: reset wins.
// CONFIGURATION
//  FETCH_TIMEOUT_EN defined:
//   - A wait counter clears on entry to REQ_HI/REQ_LO.
//   - It increments each REQ cycle without rom_ack.
//   - If TIMEOUT_CYC cycles pass with no ack: rom_rd drops, fetch_err pulses
//     for 1 cycle, state goes to IDLE.
//   - On timeout, no pc_inc is issued for the failed byte and opcode/ir_addr
//     are unchanged.
//   - rom_ack arriving in the final allowed cycle is accepted normally.
//  FETCH_TIMEOUT_EN undefined: REQ states wait forever; fetch_err is tied 0;
//   no counter logic.
// TESTING
//  1 Zero-wait: pc=0, ROM[0]=8'hA5, ROM[1]=8'h3C, fetch_start at n.
//    Expect: rom_addr=0 then 1; pc_inc at n+2,n+4; ir_valid at n+4;
//    opcode=3'b101, ir_addr=13'h053C.
//  2 Wait states: ack delayed 3 cycles per byte.
//    Expect: rom_rd/rom_addr held stable; ir_valid at n+10; still exactly 2 pc_inc.
//  3 fetch_start held high through a whole fetch.
//    Expect: second fetch begins only from IDLE at n+5; no extra pc_inc; busy low
//    exactly 1 cycle.
//  4 rst_n=0 during REQ_LO.
//    Expect: next cycle all outputs 0, state IDLE, only 1 pc_inc seen; a following
//    fetch completes normally.
//  5 FETCH_TIMEOUT_EN, TIMEOUT_CYC=15, rom_ack never asserted in REQ_HI.
//    Expect: rom_rd high 15 cycles, fetch_err 1 cycle, zero pc_inc, opcode/ir_addr
//    unchanged.
//  6 pc=13'h1FFF, ROM[1FFF]=8'hFF, ROM[0]=8'h01.
//    Expect: rom_addr 1FFF then 0000; opcode=3'b111, ir_addr=13'h1F01.

Source files
------------

// File: rtl/instr_fetch.sv
// Instruction fetch/IR unit: reads a two-byte instruction (high byte first) from a byte-wide ROM
// and assembles {opcode, ir_addr}. Optional ROM wait timeout is enabled with `define FETCH_TIMEOUT_EN.
//
// state  | meaning
// IDLE   | waiting for fetch_start; rom_addr captured on exit
// REQ_HI | rom_rd held until ack; high byte latched
// INC_HI | pc_inc pulse for the high byte; rom_addr recaptured on exit
// REQ_LO | rom_rd held until ack; instruction register loaded
// DONE   | pc_inc + ir_valid pulse

module instr_fetch #(
    parameter int ADDR_W      = 13,
    parameter int OPC_W       = 3,
    parameter int BYTE_W      = 8,
    parameter int TIMEOUT_CYC = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch_start,
    input  logic [ADDR_W-1:0] pc_addr,
    output logic              pc_inc,
    output logic              rom_rd,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic              rom_ack,
    input  logic [BYTE_W-1:0] rom_data,
    output logic [OPC_W-1:0]  opcode,
    output logic [ADDR_W-1:0] ir_addr,
    output logic              ir_valid,
    output logic              busy,
    output logic              fetch_err
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        REQ_HI = 3'd1,
        INC_HI = 3'd2,
        REQ_LO = 3'd3,
        DONE   = 3'd4
    } state_t;

    generate
        if ((OPC_W + ADDR_W != 2 * BYTE_W) || (TIMEOUT_CYC < 2)) begin : g_bad_param
            $error("instr_fetch: illegal parameter combination");
        end
    endgenerate

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   rom_addr_q, rom_addr_d;
    logic [ADDR_W-1:0]   ir_addr_q, ir_addr_d;
    logic [OPC_W-1:0]    opcode_q, opcode_d;
    logic [BYTE_W-1:0]   hi_q, hi_d;
    logic                rom_rd_q, rom_rd_d;
    logic                pc_inc_q, pc_inc_d;
    logic                ir_valid_q, ir_valid_d;
    logic                busy_q, busy_d;
    logic                ack_ok;
    logic                in_req;
    logic                timeout_hit;

    // An ack only counts while a read is actually outstanding.
    assign ack_ok = rom_ack & rom_rd_q;
    assign in_req = (state_q == REQ_HI) || (state_q == REQ_LO);

`ifdef FETCH_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC);

    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             fetch_err_q, fetch_err_d;

    // An ack in the last allowed cycle wins over the timeout.
    assign timeout_hit = in_req && !ack_ok && (wait_cnt_q == CNT_W'(TIMEOUT_CYC - 1));
    assign fetch_err_d = timeout_hit;

    always_comb begin
        wait_cnt_d = '0;
        if (in_req && (state_d == state_q)) begin
            wait_cnt_d = wait_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wait_cnt_q  <= '0;
            fetch_err_q <= 1'b0;
        end else begin
            wait_cnt_q  <= wait_cnt_d;
            fetch_err_q <= fetch_err_d;
        end
    end

    assign fetch_err = fetch_err_q;
`else
    assign timeout_hit = 1'b0;
    assign fetch_err   = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        rom_addr_d = rom_addr_q;
        hi_d       = hi_q;
        opcode_d   = opcode_q;
        ir_addr_d  = ir_addr_q;

        case (state_q)
            IDLE: begin
                if (fetch_start) begin
                    state_d    = REQ_HI;
                    rom_addr_d = pc_addr;
                end
            end
            REQ_HI: begin
                if (ack_ok) begin
                    hi_d    = rom_data;
                    state_d = INC_HI;
                end else if (timeout_hit) begin
                    state_d = IDLE;
                end
            end
            INC_HI: begin
                state_d    = REQ_LO;
                rom_addr_d = pc_addr;
            end
            REQ_LO: begin
                if (ack_ok) begin
                    {opcode_d, ir_addr_d} = {hi_q, rom_data};
                    state_d               = DONE;
                end else if (timeout_hit) begin
                    state_d = IDLE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are registered, so decode them from the next state.
        rom_rd_d   = (state_d == REQ_HI) || (state_d == REQ_LO);
        pc_inc_d   = (state_d == INC_HI) || (state_d == DONE);
        ir_valid_d = (state_d == DONE);
        busy_d     = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rom_addr_q <= '0;
            hi_q       <= '0;
            opcode_q   <= '0;
            ir_addr_q  <= '0;
            rom_rd_q   <= 1'b0;
            pc_inc_q   <= 1'b0;
            ir_valid_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            rom_addr_q <= rom_addr_d;
            hi_q       <= hi_d;
            opcode_q   <= opcode_d;
            ir_addr_q  <= ir_addr_d;
            rom_rd_q   <= rom_rd_d;
            pc_inc_q   <= pc_inc_d;
            ir_valid_q <= ir_valid_d;
            busy_q     <= busy_d;
        end
    end

    assign rom_rd   = rom_rd_q;
    assign rom_addr = rom_addr_q;
    assign pc_inc   = pc_inc_q;
    assign opcode   = opcode_q;
    assign ir_addr  = ir_addr_q;
    assign ir_valid = ir_valid_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: ROM responder with random wait states, a PC model driven by pc_inc,
// and a scoreboard comparing each ir_valid against {ROM[pc], ROM[pc+1]}.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fetch_start = 1'b0;
    logic [12:0] pc_addr;
    logic        pc_inc;
    logic        rom_rd;
    logic [12:0] rom_addr;
    logic        rom_ack = 1'b0;
    logic [7:0]  rom_data = 8'h00;
    logic [2:0]  opcode;
    logic [12:0] ir_addr;
    logic        ir_valid;
    logic        busy;
    logic        fetch_err;

    instr_fetch #(.ADDR_W(13), .OPC_W(3), .BYTE_W(8), .TIMEOUT_CYC(15)) dut (
        .clk(clk), .rst_n(rst_n), .fetch_start(fetch_start), .pc_addr(pc_addr),
        .pc_inc(pc_inc), .rom_rd(rom_rd), .rom_addr(rom_addr), .rom_ack(rom_ack),
        .rom_data(rom_data), .opcode(opcode), .ir_addr(ir_addr), .ir_valid(ir_valid),
        .busy(busy), .fetch_err(fetch_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0]  rom [0:8191];
    logic [15:0] exp_q [$];
    logic [12:0] addr_log [$];
    int          inc_log [$];
    int          n_checks = 0;
    int          n_fail = 0;

    // PC model: the PC advances once per observed pc_inc, offset from a base the stimulus sets.
    logic [12:0] pc_base = 13'h0;
    int          inc_snap = 0;
    int          inc_total = 0;
    assign pc_addr = pc_base + 13'(inc_total - inc_snap);

    int  ir_cnt = 0, err_cnt = 0, rd_cnt = 0, busy_lo_cnt = 0, ir_cyc = 0;
    bit  prev_inc = 1'b0;
    bit  active = 1'b0;
    int  w = 0, dly = 0, fixed_dly = 0;
    bit  rand_dly = 1'b0, spurious = 1'b0, never_ack = 1'b0;
    logic [12:0] held_addr = 13'h0;
    logic [15:0] e;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor + ROM responder, both sampling away from the active edge.
    always @(negedge clk) begin
        if (pc_inc) begin
            inc_total++;
            inc_log.push_back(cyc + 1);
            chk("pc_inc_back_to_back", {31'd0, prev_inc}, 0);
        end
        prev_inc = pc_inc;
        if (ir_valid) begin
            ir_cnt++;
            ir_cyc = cyc + 1;
            if (exp_q.size() == 0) begin
                chk("ir_valid_unexpected", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("sb_opcode", {29'd0, opcode}, {29'd0, e[15:13]});
                chk("sb_ir_addr", {19'd0, ir_addr}, {19'd0, e[12:0]});
            end
        end
        if (fetch_err) err_cnt++;
        if (rom_rd) rd_cnt++;
        if (!busy) busy_lo_cnt++;

        if (rom_rd) begin
            if (!active) begin
                active    = 1'b1;
                w         = 0;
                held_addr = rom_addr;
                dly       = rand_dly ? int'($urandom_range(0, 3)) : fixed_dly;
            end else begin
                chk("rom_addr_stable", {19'd0, rom_addr}, {19'd0, held_addr});
            end
            if (!never_ack && w >= dly) begin
                rom_ack  = 1'b1;
                rom_data = rom[rom_addr];
                addr_log.push_back(rom_addr);
            end else begin
                rom_ack  = 1'b0;
                rom_data = 8'($urandom);
            end
            w++;
        end else begin
            active   = 1'b0;
            rom_ack  = spurious ? 1'($urandom_range(0, 1)) : 1'b0;
            rom_data = 8'($urandom);
        end
    end

    int n, s_inc, s_ir, s_err, s_rd, s_log, s_inclog, b0;
    logic [2:0]  save_op;
    logic [12:0] save_ia, p;

    task automatic snap();
        s_inc    = inc_total;
        s_ir     = ir_cnt;
        s_err    = err_cnt;
        s_rd     = rd_cnt;
        s_log    = addr_log.size();
        s_inclog = inc_log.size();
    endtask

    task automatic set_pc(input logic [12:0] v);
        pc_base  = v;
        inc_snap = inc_total;
    endtask

    task automatic wait_idle(input bit noise);
        bit ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
            // Requests while a fetch is in flight must be ignored.
            if (noise) fetch_start = rom_rd ? 1'($urandom_range(0, 1)) : 1'b0;
        end
        fetch_start = 1'b0;
        chk("idle_reached", {31'd0, ok}, 1);
    endtask

    task automatic push_exp(input logic [12:0] a);
        logic [12:0] a1;
        a1 = a + 13'd1;
        exp_q.push_back({rom[a], rom[a1]});
    endtask

    task automatic start_fetch(output int nn, input bit expect_done);
        wait_idle(1'b0);
        fetch_start = 1'b1;
        if (expect_done) push_exp(pc_addr);
        @(posedge clk);
        #1;
        nn = cyc;
        fetch_start = 1'b0;
        snap();
    endtask

    task automatic finish_fetch(input bit noise);
        wait_idle(noise);
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_rom_rd"}, {31'd0, rom_rd}, 0);
        chk({tag, "_rom_addr"}, {19'd0, rom_addr}, 0);
        chk({tag, "_pc_inc"}, {31'd0, pc_inc}, 0);
        chk({tag, "_opcode"}, {29'd0, opcode}, 0);
        chk({tag, "_ir_addr"}, {19'd0, ir_addr}, 0);
        chk({tag, "_ir_valid"}, {31'd0, ir_valid}, 0);
        chk({tag, "_busy"}, {31'd0, busy}, 0);
        chk({tag, "_fetch_err"}, {31'd0, fetch_err}, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 8192; i++) rom[i] = 8'($urandom);
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Zero-wait fetch from address 0
        rom[0] = 8'hA5;
        rom[1] = 8'h3C;
        fixed_dly = 0;
        set_pc(13'h0000);
        start_fetch(n, 1'b1);
        finish_fetch(1'b0);
        chk("t1_ir_valid_cycle", ir_cyc - n, 4);
        chk("t1_pc_inc_count", inc_total - s_inc, 2);
        chk("t1_pc_inc_first", inc_log[s_inclog], n + 2);
        chk("t1_pc_inc_second", inc_log[s_inclog + 1], n + 4);
        chk("t1_rom_addr_hi", {19'd0, addr_log[s_log]}, 32'h0);
        chk("t1_rom_addr_lo", {19'd0, addr_log[s_log + 1]}, 32'h1);
        chk("t1_opcode", {29'd0, opcode}, 32'h5);
        chk("t1_ir_addr", {19'd0, ir_addr}, 32'h053C);

        // Three wait cycles per byte
        fixed_dly = 3;
        set_pc(13'($urandom));
        start_fetch(n, 1'b1);
        finish_fetch(1'b0);
        chk("t2_ir_valid_cycle", ir_cyc - n, 10);
        chk("t2_pc_inc_count", inc_total - s_inc, 2);
        chk("t2_rom_rd_cycles", rd_cnt - s_rd, 8);

        // fetch_start held high across a whole fetch
        fixed_dly = 0;
        set_pc(13'($urandom));
        wait_idle(1'b0);
        fetch_start = 1'b1;
        p = pc_addr;
        push_exp(p);
        push_exp(p + 13'd2);
        @(posedge clk);
        #1;
        n = cyc;
        snap();
        b0 = busy_lo_cnt;
        repeat (5) @(posedge clk);
        #1;
        fetch_start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("t3_busy_low_cycles", busy_lo_cnt - b0, 1);
        finish_fetch(1'b0);
        chk("t3_pc_inc_count", inc_total - s_inc, 4);
        chk("t3_ir_valid_count", ir_cnt - s_ir, 2);
        chk("t3_second_ir_valid_cycle", ir_cyc - n, 9);

        // Reset while in REQ_LO, coinciding with rom_ack
        fixed_dly = 2;
        set_pc(13'($urandom));
        start_fetch(n, 1'b0);
        repeat (6) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check_all_zero("t4_abort");
        chk("t4_pc_inc_before_abort", inc_total - s_inc, 1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("t4_pc_inc_after_abort", inc_total - s_inc, 1);
        chk("t4_no_ir_valid", ir_cnt - s_ir, 0);
        fixed_dly = 0;
        start_fetch(n, 1'b1);
        finish_fetch(1'b0);
        chk("t4_refetch_pc_inc", inc_total - s_inc, 2);
        chk("t4_refetch_ir_valid_cycle", ir_cyc - n, 4);

        // Address wrap at the top of the ROM
        rom[13'h1FFF] = 8'hFF;
        rom[0] = 8'h01;
        set_pc(13'h1FFF);
        start_fetch(n, 1'b1);
        finish_fetch(1'b0);
        chk("t6_rom_addr_hi", {19'd0, addr_log[s_log]}, 32'h1FFF);
        chk("t6_rom_addr_lo", {19'd0, addr_log[s_log + 1]}, 32'h0000);
        chk("t6_opcode", {29'd0, opcode}, 32'h7);
        chk("t6_ir_addr", {19'd0, ir_addr}, 32'h1F01);

`ifdef FETCH_TIMEOUT_EN
        // ROM never answers the high-byte read
        never_ack = 1'b1;
        save_op = opcode;
        save_ia = ir_addr;
        set_pc(13'($urandom));
        start_fetch(n, 1'b0);
        finish_fetch(1'b0);
        never_ack = 1'b0;
        chk("t5_rom_rd_cycles", rd_cnt - s_rd, 15);
        chk("t5_fetch_err_pulses", err_cnt - s_err, 1);
        chk("t5_pc_inc_count", inc_total - s_inc, 0);
        chk("t5_opcode_held", {29'd0, opcode}, {29'd0, save_op});
        chk("t5_ir_addr_held", {19'd0, ir_addr}, {19'd0, save_ia});
        // Ack in the final allowed cycle is still accepted
        fixed_dly = 14;
        start_fetch(n, 1'b1);
        finish_fetch(1'b0);
        fixed_dly = 0;
        chk("t5_late_ack_ir_valid", ir_cnt - s_ir, 1);
        chk("t5_late_ack_no_err", err_cnt - s_err, 0);
        chk("t5_late_ack_pc_inc", inc_total - s_inc, 2);
`endif

        // Random addresses, wait states, stray acks and ignored requests
        rand_dly = 1'b1;
        spurious = 1'b1;
        for (int k = 0; k < 40; k++) begin
            set_pc(13'($urandom));
            start_fetch(n, 1'b1);
            finish_fetch(1'b1);
            chk("rnd_pc_inc_count", inc_total - s_inc, 2);
            chk("rnd_ir_valid_count", ir_cnt - s_ir, 1);
        end
        rand_dly = 1'b0;
        spurious = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("sb_queue_empty", exp_q.size(), 0);
`ifndef FETCH_TIMEOUT_EN
        chk("no_fetch_err", err_cnt, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
